// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store engine between the multicycle control unit and the unified
//   instruction/data memory bus. It takes one request from IDLE, decodes the
//   RV32I width code and checks alignment. For stores it steers the bytes onto
//   lanes and builds write strobes. For loads it selects the lane and applies
//   sign or zero extension. It then runs a valid/ready bus handshake that is
//   bounded by a wait-state timeout.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req, we, funct3,  access request and its attributes, sampled in IDLE
//   addr, wdata
//   rdata             extended load result, held until the next load completes
//   done, err         one-cycle completion pulse, error flag qualified by done
//   busy              high whenever the unit is not IDLE
//   bus_valid/ready   memory handshake (read data valid with ready)
//   bus_we, bus_addr, registered bus request, held stable while bus_valid
//   bus_wstrb, bus_wdata
//   bus_rdata         raw read word from memory
//
// Parameter
//   TIMEOUT           max bus_valid cycles without bus_ready; 0 = no timeout

module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // The counter only has to reach TIMEOUT-1.
   localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic [CW-1:0] wait_cnt;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;

   // Request decode, evaluated on the live request inputs in IDLE.
   logic        legal;
   logic        aligned;
   logic [3:0]  wstrb_n;
   logic [31:0] wdata_n;

   always_comb begin
      legal   = 1'b0;
      aligned = 1'b0;
      wstrb_n = 4'b0000;
      wdata_n = 32'h0;
      case (funct3)
         3'b000: begin
            legal   = 1'b1;
            aligned = 1'b1;
            wstrb_n = 4'b0001 << addr[1:0];
            wdata_n = {4{wdata[7:0]}};
         end
         3'b001: begin
            legal   = 1'b1;
            aligned = ~addr[0];
            wstrb_n = 4'b0011 << {addr[1], 1'b0};
            wdata_n = {2{wdata[15:0]}};
         end
         3'b010: begin
            legal   = 1'b1;
            aligned = (addr[1:0] == 2'b00);
            wstrb_n = 4'hF;
            wdata_n = wdata;
         end
         3'b100: begin
            legal   = ~we;
            aligned = 1'b1;
         end
         3'b101: begin
            legal   = ~we;
            aligned = ~addr[0];
         end
         default: begin
            legal   = 1'b0;
            aligned = 1'b0;
         end
      endcase
      // Loads never drive strobes or data onto the bus.
      if (!we) begin
         wstrb_n = 4'b0000;
         wdata_n = 32'h0;
      end
   end

   // Lane selection and extension of a returned read word.
   function automatic logic [31:0] load_ext(input logic [31:0] w,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{24{b[7]}}, b};
         3'b001:  load_ext = {{16{h[15]}}, h};
         3'b100:  load_ext = {24'h0, b};
         3'b101:  load_ext = {16'h0, h};
         default: load_ext = w;
      endcase
   endfunction

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         rdata     <= 32'h0;
         done      <= 1'b0;
         err       <= 1'b0;
         bus_valid <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wstrb <= 4'b0000;
         bus_wdata <= 32'h0;
      end else begin
         // done/err are pulses; only the transition into DONE raises them.
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  f3_q  <= funct3;
                  off_q <= addr[1:0];
                  if (legal && aligned) begin
                     state     <= S_BUS;
                     wait_cnt  <= '0;
                     bus_valid <= 1'b1;
                     bus_we    <= we;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_wstrb <= wstrb_n;
                     bus_wdata <= wdata_n;
                  end else begin
                     // Rejected before any bus activity; rdata keeps its value.
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            S_BUS: begin
               // A ready in the terminal-count cycle still completes normally.
               if (bus_ready) begin
                  state     <= S_DONE;
                  bus_valid <= 1'b0;
                  done      <= 1'b1;
                  if (!bus_we)
                     rdata <= load_ext(bus_rdata, f3_q, off_q);
               end else if ((TIMEOUT != 0) && (wait_cnt == TERM)) begin
                  state     <= S_DONE;
                  bus_valid <= 1'b0;
                  done      <= 1'b1;
                  err       <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DONE: begin
               // A request that arrives in this cycle is dropped, not deferred.
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT overridden to 4).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic [31:0] rdata;
   logic        done, err, busy, bus_valid, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;

   int errors = 0;
   int checks = 0;

   mem_access_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
      .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
   endtask

   task automatic test_reset;
      #12;
      checks++; if ({done, err, busy, bus_valid, bus_we, bus_wstrb} !== 9'h0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {done, err, busy, bus_valid, bus_we, bus_wstrb}); end
      checks++; if ({rdata, bus_addr, bus_wdata} !== 96'h0) begin errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", rdata, bus_addr, bus_wdata); end
      @(negedge clk); rst = 1'b0;
      step;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_lw;
      issue(1'b0, 3'b010, 32'h100, 32'h0); bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
      step; req = 1'b0;
      checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h100 || bus_wstrb !== 4'h0 || bus_we !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
         begin errors++; $display("FAIL lw_bus: valid=%b addr=%h wstrb=%b we=%b done=%b busy=%b want 1 100 0000 0 0 1", bus_valid, bus_addr, bus_wstrb, bus_we, done, busy); end
      step;
      checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEADBEEF || bus_valid !== 1'b0)
         begin errors++; $display("FAIL lw_done: done=%b err=%b rdata=%h valid=%b want 1 0 deadbeef 0", done, err, rdata, bus_valid); end
      bus_ready = 1'b0;
      step;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lw_idle: done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic load_one(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] word,
                           input logic [31:0] exp_addr, input logic [31:0] exp);
      issue(1'b0, f, a, 32'h0); bus_ready = 1'b1; bus_rdata = word;
      step; req = 1'b0;
      checks++; if (bus_valid !== 1'b1 || bus_addr !== exp_addr) begin errors++; $display("FAIL %s_bus: valid=%b addr=%h want 1 %h", nm, bus_valid, bus_addr, exp_addr); end
      step;
      checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== exp) begin errors++; $display("FAIL %s_data: done=%b err=%b rdata=%h want 1 0 %h", nm, done, err, rdata, exp); end
      bus_ready = 1'b0;
      step;
   endtask

   task automatic test_load_ext;
      load_one("lb",  3'b000, 32'h203, 32'h80112233, 32'h200, 32'hFFFFFF80);
      load_one("lbu", 3'b100, 32'h203, 32'h80112233, 32'h200, 32'h00000080);
      load_one("lh",  3'b001, 32'h200, 32'h80119233, 32'h200, 32'hFFFF9233);
      load_one("lhu", 3'b101, 32'h202, 32'h80112233, 32'h200, 32'h00008011);
   endtask

   task automatic test_store;
      // sh with three wait states; ready arrives on the 4th (terminal) bus cycle.
      issue(1'b1, 3'b001, 32'h306, 32'h0000ABCD); bus_ready = 1'b0;
      step; req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus_valid !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h304 || bus_wstrb !== 4'b1100 || bus_wdata !== 32'hABCDABCD || done !== 1'b0)
            begin errors++; $display("FAIL sh_hold%0d: valid=%b we=%b addr=%h wstrb=%b wdata=%h done=%b", i, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata, done); end
         if (i == 4) bus_ready = 1'b1;
         step;
      end
      checks++; if (done !== 1'b1 || err !== 1'b0 || bus_valid !== 1'b0 || rdata !== 32'h00008011)
         begin errors++; $display("FAIL sh_done: done=%b err=%b valid=%b rdata=%h want 1 0 0 00008011", done, err, bus_valid, rdata); end
      bus_ready = 1'b0;
      step;
      // sb at the top byte lane
      issue(1'b1, 3'b000, 32'h0FF, 32'h1234565A); bus_ready = 1'b1;
      step; req = 1'b0;
      checks++; if (bus_addr !== 32'h0FC || bus_wstrb !== 4'b1000 || bus_wdata !== 32'h5A5A5A5A)
         begin errors++; $display("FAIL sb_bus: addr=%h wstrb=%b wdata=%h want 0fc 1000 5a5a5a5a", bus_addr, bus_wstrb, bus_wdata); end
      step; bus_ready = 1'b0;
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL sb_done: done=%b err=%b want 1 0", done, err); end
      step;
      // sw
      issue(1'b1, 3'b010, 32'h408, 32'h01020304); bus_ready = 1'b1;
      step; req = 1'b0;
      checks++; if (bus_addr !== 32'h408 || bus_wstrb !== 4'hF || bus_wdata !== 32'h01020304)
         begin errors++; $display("FAIL sw_bus: addr=%h wstrb=%b wdata=%h want 408 1111 01020304", bus_addr, bus_wstrb, bus_wdata); end
      step; bus_ready = 1'b0;
      step;
   endtask

   task automatic err_one(input string nm, input logic w, input logic [2:0] f, input logic [31:0] a);
      issue(w, f, a, 32'hFFFFFFFF); bus_ready = 1'b1; bus_rdata = 32'h55555555;
      step; req = 1'b0;
      checks++; if (bus_valid !== 1'b0 || done !== 1'b1 || err !== 1'b1 || busy !== 1'b1 || rdata !== 32'h00008011)
         begin errors++; $display("FAIL %s: valid=%b done=%b err=%b busy=%b rdata=%h want 0 1 1 1 00008011", nm, bus_valid, done, err, busy, rdata); end
      step;
      checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || bus_valid !== 1'b0)
         begin errors++; $display("FAIL %s_after: done=%b err=%b busy=%b valid=%b want 0", nm, done, err, busy, bus_valid); end
      bus_ready = 1'b0;
   endtask

   task automatic test_errors;
      err_one("lw_misalign", 1'b0, 3'b010, 32'h102);
      err_one("load_f3_011", 1'b0, 3'b011, 32'h100);
      err_one("store_f3_100", 1'b1, 3'b100, 32'h100);
      err_one("sh_misalign", 1'b1, 3'b001, 32'h301);
   endtask

   task automatic test_timeout;
      issue(1'b0, 3'b010, 32'h400, 32'h0); bus_ready = 1'b0; bus_rdata = 32'h12345678;
      step; req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_wait%0d: valid=%b done=%b want 1 0", i, bus_valid, done); end
         step;
      end
      checks++; if (bus_valid !== 1'b0 || done !== 1'b1 || err !== 1'b1 || rdata !== 32'h00008011)
         begin errors++; $display("FAIL to_abort: valid=%b done=%b err=%b rdata=%h want 0 1 1 00008011", bus_valid, done, err, rdata); end
      step;
      // Ready on the terminal cycle completes normally.
      issue(1'b0, 3'b010, 32'h404, 32'h0); bus_rdata = 32'hCAFEF00D;
      step; req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) bus_ready = 1'b1;
         step;
      end
      checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFEF00D)
         begin errors++; $display("FAIL to_edge: done=%b err=%b rdata=%h want 1 0 cafef00d", done, err, rdata); end
      bus_ready = 1'b0;
      step;
   endtask

   task automatic test_reset_mid;
      int dones;
      issue(1'b1, 3'b010, 32'h700, 32'hA5A5A5A5); bus_ready = 1'b0;
      step; req = 1'b0;
      checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: valid=%b want 1", bus_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({done, err, busy, bus_valid, bus_we, bus_wstrb} !== 9'h0 || {rdata, bus_addr, bus_wdata} !== 96'h0)
         begin errors++; $display("FAIL rmid_async: ctrl=%b rdata=%h addr=%h wdata=%h want 0", {done, err, busy, bus_valid, bus_we, bus_wstrb}, rdata, bus_addr, bus_wdata); end
      step;
      @(negedge clk); rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 4; i++) begin step; if (done === 1'b1 || bus_valid === 1'b1) dones++; end
      checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_after: activity=%0d want 0", dones); end
   endtask

   task automatic test_back_to_back;
      int dones;
      dones = 0;
      issue(1'b0, 3'b010, 32'h500, 32'h0); bus_ready = 1'b0; bus_rdata = 32'h11223344;
      step;
      addr = 32'h600;                  // second request while busy
      step; req = 1'b0; bus_ready = 1'b1;
      checks++; if (bus_addr !== 32'h500 || bus_valid !== 1'b1) begin errors++; $display("FAIL b2b_addr: addr=%h valid=%b want 500 1", bus_addr, bus_valid); end
      step; bus_ready = 1'b0;
      if (done === 1'b1) dones++;
      req = 1'b1;                      // request during the DONE cycle
      step; req = 1'b0;
      if (done === 1'b1) dones++;
      for (int i = 0; i < 4; i++) begin
         step;
         if (done === 1'b1) dones++;
         if (bus_valid === 1'b1) dones += 10;
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_count: done-events=%0d want 1", dones); end
      checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL b2b_rdata: got %h want 11223344", rdata); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
